// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - combinational 1-bit full adder cell
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the odd-parity of the three inputs; carry is their majority.
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered WIDTH-bit ripple-carry full adder
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic             in_2,
  output logic [WIDTH-1:0] sum,
  output logic             cnt
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cnt_d;
  logic             cnt_q;

  assign carry[0] = in_2;

  // Ripple chain: cell i consumes carry[i] and produces carry[i+1].
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (in_0[i]),
      .b  (in_1[i]),
      .ci (carry[i]),
      .s  (sum_bits[i]),
      .co (carry[i+1])
    );
  end

  // Next-state for the output register: the raw ripple result.
  always_comb begin
    sum_d = sum_bits;
    cnt_d = carry[WIDTH];
  end

  // Output stage: one-cycle latency, reset clears and drops the in-flight result.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sum_q <= '0;
      cnt_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum = sum_q;
  assign cnt = cnt_q;

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - self-checking bench for full_adder at WIDTH=1 and WIDTH=8
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, cin;
  logic       s1, c1;
  logic [7:0] a8, b8;
  logic [7:0] s8;
  logic       c8;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected values from the previous sampling edge
  logic [1:0] exp1;
  logic [8:0] exp8;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .sys_clk (clk),
    .sys_rst (rst),
    .in_0    (a1),
    .in_1    (b1),
    .in_2    (cin),
    .sum     (s1),
    .cnt     (c1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .sys_clk (clk),
    .sys_rst (rst),
    .in_0    (a8),
    .in_1    (b8),
    .in_2    (cin),
    .sum     (s8),
    .cnt     (c8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain unsigned addition of the current inputs
  task automatic model();
    int t1, t8;
    t1 = int'(a1) + int'(b1) + int'(cin);
    t8 = int'(a8) + int'(b8) + int'(cin);
    exp1 = t1[1:0];
    exp8 = t8[8:0];
  endtask

  initial begin
    logic [7:0] tt_sum;
    logic [7:0] tt_cnt;
    logic [2:0] v;
    tt_sum = 8'b1001_0110;
    tt_cnt = 8'b1110_1000;

    // Reset with all inputs high: outputs must stay zero
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; cin = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    cycle();
    chk("rst1_w1", {30'd0, c1, s1}, 32'd0);
    chk("rst1_w8", {23'd0, c8, s8}, 32'd0);
    cycle();
    chk("rst2_w1", {30'd0, c1, s1}, 32'd0);
    chk("rst2_w8", {23'd0, c8, s8}, 32'd0);

    // Exhaustive 1-bit truth table, one combination per cycle
    rst = 1'b0;
    exp1 = 2'b00;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, cin} = v;
      a8 = 8'($urandom); b8 = 8'($urandom);
      #1;
      if (i > 0) chk("tt_hold", {30'd0, c1, s1}, {30'd0, exp1});
      model();
      cycle();
      chk($sformatf("tt_%0d_sum", i), {31'd0, s1}, {31'd0, tt_sum[i]});
      chk($sformatf("tt_%0d_cnt", i), {31'd0, c1}, {31'd0, tt_cnt[i]});
      chk($sformatf("tt_%0d_w8", i), {23'd0, c8, s8}, {23'd0, exp8});
    end

    // Mid-stream reset discards the in-flight result
    a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
    cycle();
    chk("mid_pre", {30'd0, c1, s1}, 32'd3);
    rst = 1'b1;
    cycle();
    chk("mid_rst_w1", {30'd0, c1, s1}, 32'd0);
    chk("mid_rst_w8", {23'd0, c8, s8}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("mid_resume", {30'd0, c1, s1}, 32'd3);

    // 8-bit corners
    a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1;
    cycle();
    chk("w8_allones", {23'd0, c8, s8}, {23'd0, 1'b1, 8'hFF});
    a8 = 8'h80; b8 = 8'h80; cin = 1'b0;
    cycle();
    chk("w8_msb", {23'd0, c8, s8}, {23'd0, 1'b1, 8'h00});
    a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
    cycle();
    chk("zeros_w8", {23'd0, c8, s8}, 32'd0);
    chk("zeros_w1", {30'd0, c1, s1}, 32'd0);

    // Random back-to-back: results held until the edge, then exact sum
    exp1 = 2'b00; exp8 = 9'd0;
    for (int i = 0; i < 1000; i++) begin
      a1 = 1'($urandom % 2); b1 = 1'($urandom % 2); cin = 1'($urandom % 2);
      a8 = 8'($urandom); b8 = 8'($urandom);
      #1;
      chk("rnd_hold_w1", {30'd0, c1, s1}, {30'd0, exp1});
      chk("rnd_hold_w8", {23'd0, c8, s8}, {23'd0, exp8});
      model();
      cycle();
      chk("rnd_w1", {30'd0, c1, s1}, {30'd0, exp1});
      chk("rnd_w8", {23'd0, c8, s8}, {23'd0, exp8});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder: adds two WIDTH-bit operands `in_0`, `in_1` and a 1-bit carry-in `in_2`.
- Produces a WIDTH-bit `sum` and a carry-out `cnt`.
- With default WIDTH=1 it is the classic 1-bit full adder (sum = a^b^c, cnt = majority).
- Leaf arithmetic block, used standalone or as a building element for wider adders/counters.

Parameters:
- WIDTH, 1, bit width of operands `in_0`/`in_1` and of `sum`; legal range 1..32.

Ports:
- sys_clk  input  1  system clock; all state updates on rising edge
- sys_rst  input  1  synchronous reset, active-high
- in_0  input  WIDTH  operand A
- in_1  input  WIDTH  operand B
- in_2  input  1  carry-in
- sum  output  WIDTH  registered sum bits, (A+B+Cin) mod 2^WIDTH
- cnt  output  1  registered carry-out, bit WIDTH of A+B+Cin

Interface (already decided):
- One clock.
- Reset is synchronous and active-high.

Behaviour:
- Combinational core: ripple chain of WIDTH 1-bit cells.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (a_i & c_i) | (b_i & c_i).
  - c_0 = in_2. Carry-out is c_WIDTH.
- Output registers:
  - On each rising `sys_clk` edge with `sys_rst`=0: `sum` <= s[WIDTH-1:0], `cnt` <= c_WIDTH.
  - Latency exactly 1 cycle from input change to output.
  - No bubbles, no enable: a new result every cycle.
- Reset:
  - On a rising edge with `sys_rst`=1: `sum` <= 0, `cnt` <= 0. Inputs are ignored that cycle.
  - Reset asserted mid-stream discards the in-flight result.
  - First post-reset output reflects the inputs sampled at the first edge with `sys_rst`=0.
- Arithmetic: unsigned. Identity {cnt, sum} == in_0 + in_1 + in_2 (WIDTH+1 bits) holds one cycle after sampling.
- Boundaries:
  - All-ones + all-ones + 1 gives sum = all-ones, cnt = 1.
  - All zeros gives 0/0.
  - No overflow flag beyond `cnt`.
- Before the first clock edge, outputs are don't-care; the bench must reset before checking.
- No X propagation requirements beyond standard: X inputs may yield X outputs.

Decomposition:
- No shared package needed; WIDTH is the only constant.
- One sub-module: `full_adder_cell`.
  - Purely combinational 1-bit full adder: ports `a`, `b`, `ci`, `s`, `co`.
  - Instantiated WIDTH times via generate loop; the top adds the output register stage.

Test Plan:
- Reset: drive `sys_rst`=1 for 2 cycles with in_0=1, in_1=1, in_2=1 -> `sum`=0, `cnt`=0 throughout reset.
- Exhaustive truth table (WIDTH=1): apply all 8 combinations, one per cycle.
  - 000->0/0, 001->1/0, 010->1/0, 011->0/1, 100->1/0, 101->0/1, 110->0/1, 111->1/1 (`sum`/`cnt`).
  - Each result appears exactly 1 cycle after its inputs.
- Latency/back-to-back: change inputs every cycle; the output at cycle n+1 matches the inputs at cycle n, with no skipped or repeated results.
- Reset mid-stream: inputs 1,1,1 then assert `sys_rst` for one cycle -> next output 0/0; after deassert, output resumes 1/1 one cycle later.
- Random: 1000 cycles of random {in_0, in_1, in_2} (as with {$random}%2) -> {cnt, sum} == in_0+in_1+in_2 (previous cycle) every cycle.
- WIDTH=8 corner: in_0=8'hFF, in_1=8'hFF, in_2=1 -> sum=8'hFF, cnt=1; in_0=8'h80, in_1=8'h80, in_2=0 -> sum=8'h00, cnt=1.
